// File: rtl/sr_latch_sequencer_pkg.sv
// Shared types, encodings and width helpers for the RS-latch sequencer.
package sr_latch_sequencer_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_RECOVER = 2'd2,
      ST_CHECK   = 2'd3
   } state_t;

   // Requested latch operation
   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   // Width of a requester index; at least one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of the phase down-counter: clog2(max(pulse,gap)+1)
   function automatic int unsigned cnt_width(input int unsigned pulse, input int unsigned gap);
      int unsigned m;
      m = (pulse > gap) ? pulse : gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sr_latch_sequencer_if.sv
// Requester handshake plus latch drive/sense signals for the sequencer.
interface sr_latch_sequencer_if
   import sr_latch_sequencer_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned IW = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] op;
   logic [NUM_REQ-1:0] gnt;
   logic               done;
   logic [IW-1:0]      done_id;
   logic               err;
   logic               busy;
   logic               s_n;
   logic               r_n;
   logic               q;

   // Requesters and the latch side
   modport master (
      output req, op, q,
      input  gnt, done, done_id, err, busy, s_n, r_n
   );

   // Sequencer side
   modport slave (
      input  req, op, q,
      output gnt, done, done_id, err, busy, s_n, r_n
   );
endinterface

// File: rtl/sr_latch_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module sr_latch_sequencer_rr_arbiter
   import sr_latch_sequencer_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IW = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IW-1:0]      o_idx,
   output logic               o_valid
);

   int unsigned w_j;

   // Scan from ptr upward modulo NUM_REQ; the first hit wins
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_j     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_j = (32'(i_ptr) + i) % NUM_REQ;
         if (!o_valid && i_req[IW'(w_j)]) begin
            o_valid            = 1'b1;
            o_gnt[IW'(w_j)]    = 1'b1;
            o_idx              = IW'(w_j);
         end
      end
   end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Arbitrates set/clear requests onto one NAND RS latch: pulse, recover, check.
// The pulse drive is always complementary, so s_n and r_n are never both low.
module sr_latch_sequencer
   import sr_latch_sequencer_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned GAP_CYC   = 2
) (
   input logic                 clk,
   input logic                 rst,
   sr_latch_sequencer_if.slave bus
);

   localparam int unsigned IW = idx_width(NUM_REQ);
   localparam int unsigned CW = cnt_width(PULSE_CYC, GAP_CYC);

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [IW-1:0]      r_ptr;
   logic               r_op_q;
   logic [IW-1:0]      r_id_q;
   logic               r_boot;      // RECOVER entered from reset: skip the check
   logic               r_q_meta;
   logic               r_q_sync;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_done;
   logic [IW-1:0]      r_done_id;
   logic               r_err;
   logic               r_busy;
   logic               r_s_n;
   logic               r_r_n;

   logic [NUM_REQ-1:0] w_gnt;
   logic [IW-1:0]      w_idx;
   logic               w_valid;

   sr_latch_sequencer_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   // Two-flop synchroniser for the asynchronous latch output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q_meta <= 1'b0;
         r_q_sync <= 1'b0;
      end else begin
         r_q_meta <= bus.q;
         r_q_sync <= r_q_meta;
      end
   end

   // Sequencer FSM with registered outputs; done is reported in the cycle after CHECK
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_RECOVER;
         r_cnt     <= CW'(GAP_CYC - 1);
         r_ptr     <= '0;
         r_op_q    <= 1'b0;
         r_id_q    <= '0;
         r_boot    <= 1'b1;
         r_gnt     <= '0;
         r_done    <= 1'b0;
         r_done_id <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b1;
         r_s_n     <= 1'b1;
         r_r_n     <= 1'b0;
      end else begin
         r_gnt  <= '0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_gnt   <= w_gnt;
                  r_op_q  <= bus.op[w_idx];
                  r_id_q  <= w_idx;
                  r_ptr   <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
                  r_cnt   <= CW'(PULSE_CYC - 1);
                  r_state <= ST_PULSE;
                  r_busy  <= 1'b1;
                  r_s_n   <= (bus.op[w_idx] == OP_SET) ? 1'b0 : 1'b1;
                  r_r_n   <= (bus.op[w_idx] == OP_SET) ? 1'b1 : 1'b0;
               end
            end
            ST_PULSE: begin
               if (r_cnt == '0) begin
                  r_state <= ST_RECOVER;
                  r_cnt   <= CW'(GAP_CYC - 1);
                  r_s_n   <= 1'b1;
                  r_r_n   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_RECOVER: begin
               r_s_n <= 1'b1;
               r_r_n <= 1'b1;
               if (r_cnt == '0) begin
                  if (r_boot) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_boot  <= 1'b0;
                  end else begin
                     r_state <= ST_CHECK;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_CHECK: begin
               r_done    <= 1'b1;
               r_done_id <= r_id_q;
               r_err     <= (r_q_sync != r_op_q);
               r_state   <= ST_IDLE;
               r_busy    <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_s_n   <= 1'b1;
               r_r_n   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.done    = r_done;
   assign bus.done_id = r_done_id;
   assign bus.err     = r_err;
   assign bus.busy    = r_busy;
   assign bus.s_n     = r_s_n;
   assign bus.r_n     = r_r_n;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Scoreboard bench for sr_latch_sequencer with a behavioural NAND-latch model.
module tb_sr_latch_sequencer;
   import sr_latch_sequencer_pkg::*;

   localparam int N   = 4;
   localparam int PC  = 2;
   localparam int GC  = 2;
   localparam int LAT = PC + GC + 1;
   localparam int SPC = PC + GC + 2;

   typedef struct {
      int   id;
      logic err;
      int   gcyc;
   } exp_t;

   logic clk;
   logic rst;
   logic stuck   = 1'b0;
   logic latch_q = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   exp_t sb[$];

   sr_latch_sequencer_if #(.NUM_REQ(N)) bus();

   sr_latch_sequencer #(.NUM_REQ(N), .PULSE_CYC(PC), .GAP_CYC(GC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // NAND latch: low s_n sets, low r_n clears, otherwise holds
   always @(bus.s_n or bus.r_n) begin
      if (bus.s_n === 1'b0)      latch_q = 1'b1;
      else if (bus.r_n === 1'b0) latch_q = 1'b0;
   end
   assign bus.q = stuck ? 1'b0 : latch_q;

   // Per-cycle observation: forbidden state, grant push, done pop
   task automatic monitor();
      int   gid;
      exp_t e;
      checks++;
      if ((bus.s_n | bus.r_n) !== 1'b1) begin
         errors++;
         $display("FAIL forbidden cyc=%0d s_n=%b r_n=%b required s_n|r_n=1", cyc, bus.s_n, bus.r_n);
      end
      if (bus.gnt !== '0) begin
         checks++;
         if ($countones(bus.gnt) != 1) begin
            errors++;
            $display("FAIL gnt_onehot cyc=%0d gnt=%b required one-hot", cyc, bus.gnt);
         end else begin
            gid = 0;
            for (int i = 0; i < N; i++) if (bus.gnt[i]) gid = i;
            checks++;
            if (bus.req[gid] !== 1'b1) begin
               errors++;
               $display("FAIL gnt_req cyc=%0d gnt=%b req=%b required granted req high", cyc, bus.gnt, bus.req);
            end
            e.id   = gid;
            e.err  = stuck & bus.op[gid];
            e.gcyc = cyc;
            sb.push_back(e);
         end
      end
      if (bus.done === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected cyc=%0d done_id=%0d required no done", cyc, bus.done_id);
         end else begin
            e = sb.pop_front();
            checks++;
            if (bus.done_id !== 2'(e.id)) begin
               errors++;
               $display("FAIL done_id cyc=%0d got %0d required %0d", cyc, bus.done_id, e.id);
            end
            checks++;
            if (bus.err !== e.err) begin
               errors++;
               $display("FAIL done_err cyc=%0d id=%0d got %b required %b", cyc, e.id, bus.err, e.err);
            end
            checks++;
            if (cyc - e.gcyc != LAT) begin
               errors++;
               $display("FAIL done_latency cyc=%0d got %0d required %0d", cyc, cyc - e.gcyc, LAT);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   task automatic wait_gnt(input int budget, output int id);
      id = -1;
      for (int t = 0; t < budget; t++) begin
         tick();
         if (bus.gnt !== '0) begin
            for (int i = 0; i < N; i++) if (bus.gnt[i]) id = i;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL gnt_timeout cyc=%0d got none required grant within %0d", cyc, budget);
   endtask

   task automatic wait_done(input int budget, output logic err_o);
      err_o = 1'bx;
      for (int t = 0; t < budget; t++) begin
         tick();
         if (bus.done === 1'b1) begin
            err_o = bus.err;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL done_timeout cyc=%0d got none required done within %0d", cyc, budget);
   endtask

   task automatic drain();
      for (int t = 0; t < 40; t++) begin
         if (sb.size() == 0 && bus.busy === 1'b0) break;
         tick();
      end
      checks++;
      if (sb.size() != 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL drain cyc=%0d pending=%0d busy=%b required 0/0", cyc, sb.size(), bus.busy);
      end
   endtask

   task automatic apply_reset();
      bus.req = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      tick();
      tick();
   endtask

   task automatic test_reset();
      logic [10:0] obs;
      logic [10:0] exp;
      rst = 1'b1;
      bus.req = '0;
      bus.op  = '0;
      repeat (3) @(posedge clk);
      #1;
      obs = {bus.s_n, bus.r_n, bus.gnt, bus.done, bus.err, bus.done_id, bus.busy};
      exp = {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_outputs got %b required %b", obs, exp);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.s_n, bus.r_n, bus.busy} !== 3'b111) begin
         errors++;
         $display("FAIL reset_recover got s_n/r_n/busy=%b required 111", {bus.s_n, bus.r_n, bus.busy});
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b required 0", bus.busy);
      end
      repeat (4) begin
         tick();
         checks++;
         if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got gnt=%b busy=%b required 0000/0", bus.gnt, bus.busy);
         end
      end
   endtask

   task automatic test_single_set();
      logic [5:0] sn_pat;
      logic [2:0] obs;
      logic [2:0] exp;
      sn_pat  = 6'b111100;
      bus.op  = 4'b0001;
      bus.req = 4'b0001;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL single_gnt got %b required 0001", bus.gnt);
      end
      bus.req = '0;
      for (int k = 0; k <= LAT; k++) begin
         if (k > 0) tick();
         obs = {bus.s_n, bus.r_n, bus.done};
         exp = {sn_pat[k], 1'b1, (k == LAT) ? 1'b1 : 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single_seq k=%0d got s_n/r_n/done=%b required %b", k, obs, exp);
         end
      end
      tick();
   endtask

   task automatic test_contention();
      int order[5];
      int gc[5];
      int n;
      apply_reset();
      bus.op  = 4'b0101;
      bus.req = 4'b1111;
      n = 0;
      for (int t = 0; t < 60 && n < 5; t++) begin
         tick();
         if (bus.gnt !== '0) begin
            for (int i = 0; i < N; i++) if (bus.gnt[i]) order[n] = i;
            gc[n] = cyc;
            n++;
         end
      end
      bus.req = '0;
      checks++;
      if (n < 5) begin
         errors++;
         $display("FAIL rr_timeout got %0d grants required 5", n);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != i % N) begin
               errors++;
               $display("FAIL rr_order idx=%0d got %0d required %0d", i, order[i], i % N);
            end
         end
         for (int i = 1; i < 5; i++) begin
            checks++;
            if (gc[i] - gc[i-1] != SPC) begin
               errors++;
               $display("FAIL rr_spacing idx=%0d got %0d required %0d", i, gc[i] - gc[i-1], SPC);
            end
         end
      end
      drain();
   endtask

   task automatic test_random();
      logic [N-1:0] pend;
      pend = '0;
      bus.req = '0;
      for (int c = 0; c < 10000; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               if (bus.gnt[i]) begin
                  pend[i]    = 1'b0;
                  bus.req[i] = 1'($urandom_range(0, 1));
                  if (bus.req[i]) begin
                     pend[i]   = 1'b1;
                     bus.op[i] = 1'($urandom_range(0, 1));
                  end
               end else if ($urandom_range(0, 63) == 0) begin
                  bus.req[i] = 1'b0;
                  pend[i]    = 1'b0;
               end
            end else if ($urandom_range(0, 7) == 0) begin
               bus.req[i] = 1'b1;
               bus.op[i]  = 1'($urandom_range(0, 1));
               pend[i]    = 1'b1;
            end
         end
      end
      bus.req = '0;
      drain();
   endtask

   task automatic test_stuck();
      int   id;
      logic e;
      stuck   = 1'b1;
      bus.op  = 4'b0100;
      bus.req = 4'b0100;
      wait_gnt(20, id);
      bus.req = '0;
      wait_done(20, e);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL stuck_set_err got %b required 1", e);
      end
      drain();
      bus.op  = 4'b0000;
      bus.req = 4'b1000;
      wait_gnt(20, id);
      bus.req = '0;
      wait_done(20, e);
      checks++;
      if (e !== 1'b0) begin
         errors++;
         $display("FAIL stuck_clr_err got %b required 0", e);
      end
      drain();
      stuck = 1'b0;
   endtask

   task automatic test_reset_mid();
      int id;
      bus.op  = 4'b0001;
      bus.req = 4'b0001;
      wait_gnt(20, id);
      checks++;
      if (bus.s_n !== 1'b0) begin
         errors++;
         $display("FAIL mid_pulse got s_n=%b required 0", bus.s_n);
      end
      rst = 1'b1;
      #1;
      sb.delete();
      checks++;
      if ({bus.s_n, bus.r_n, bus.busy} !== 3'b101) begin
         errors++;
         $display("FAIL mid_reset got s_n/r_n/busy=%b required 101", {bus.s_n, bus.r_n, bus.busy});
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.s_n, bus.r_n, bus.gnt} !== 6'b110000) begin
         errors++;
         $display("FAIL mid_recover1 got %b required 110000", {bus.s_n, bus.r_n, bus.gnt});
      end
      tick();
      checks++;
      if (bus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL mid_recover2 got gnt=%b required 0000", bus.gnt);
      end
      tick();
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL mid_regrant got gnt=%b required 0001", bus.gnt);
      end
      bus.req = '0;
      drain();
   endtask

   initial begin
      rst     = 1'b1;
      bus.req = '0;
      bus.op  = '0;
      test_reset();
      test_single_set();
      test_contention();
      test_stuck();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
